// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM states and
// the byte-lane / load-extension helpers used on both halves of a split access.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, SPLIT, RESP} dmem_state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3[2] && f3[1]) || (we && f3[2]);
    endfunction

    function automatic logic crosses(input logic [2:0] f3, input logic [1:0] o);
        return ({1'b0, o} + size_bytes(f3)) > 3'd4;
    endfunction

    // Lanes over an 8-byte window: [3:0] in word w, [7:4] in word w+1.
    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] o);
        logic [7:0] base;
        case (size_bytes(f3))
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << o;
    endfunction

    function automatic logic [3:0] lo_lanes(input logic [2:0] f3, input logic [1:0] o);
        logic [7:0] m;
        m = lane_mask(f3, o);
        return m[3:0];
    endfunction

    function automatic logic [3:0] hi_lanes(input logic [2:0] f3, input logic [1:0] o);
        logic [7:0] m;
        m = lane_mask(f3, o);
        return m[7:4];
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [63:0] pair,
                                                input logic [1:0] o);
        logic [63:0] s;
        s = pair >> {o, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'd0, s[7:0]};
            F3_HU:   return {16'd0, s[15:0]};
            default: return s[31:0];
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// Handshaked RV32I data memory: byte/half/word access, misaligned accesses split
// over two RAM cycles, errors reported at accept instead of aliasing.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_next;

    logic [1:0] o;
    logic       accept, in_range, last_word, req_cross, req_err;

    assign o         = req_addr[1:0];
    assign accept    = req_valid && req_ready;
    assign in_range  = (req_addr[ADDRESS_WIDTH-1:IDX_W+2] == '0);
    assign last_word = &req_addr[IDX_W+1:2];
    assign req_cross = crosses(req_funct3, o);
    assign req_err   = f3_illegal(req_funct3, req_we) || !in_range || (req_cross && last_word);

    // Accept stage: request fields captured for the SPLIT and RESP cycles
    logic             we_p1, err_p1, cross_p1;
    logic [2:0]       f3_p1;
    logic [1:0]       o_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [31:0]      wdata_p1;

    always_ff @(posedge clk) begin
        if (accept) begin
            we_p1    <= req_we;
            err_p1   <= req_err;
            cross_p1 <= req_cross && !req_err;
            f3_p1    <= req_funct3;
            o_p1     <= o;
            idx_p1   <= req_addr[IDX_W+1:2];
            wdata_p1 <= req_wdata;
        end
    end

    logic             bank_en;
    logic [IDX_W-1:0] bank_addr;
    logic [3:0]       bank_we;
    logic [31:0]      bank_wdata, bank_rdata;

    always_comb begin
        bank_en    = accept;
        bank_addr  = req_addr[IDX_W+1:2];
        bank_we    = (accept && req_we && !req_err) ? lo_lanes(req_funct3, o) : 4'b0000;
        bank_wdata = req_wdata << {o, 3'b000};
        if (state == SPLIT) begin
            bank_en    = 1'b1;
            bank_addr  = idx_p1 + IDX_W'(1);
            bank_we    = we_p1 ? hi_lanes(f3_p1, o_p1) : 4'b0000;
            bank_wdata = wdata_p1 >> {3'd4 - {1'b0, o_p1}, 3'b000};
        end
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .addr (bank_addr),
        .we   (bank_we),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    // Split stage: lower word read at accept must survive the upper-word read
    logic [31:0] lower_p2;

    always_ff @(posedge clk) begin
        if (state == SPLIT) begin
            lower_p2 <= bank_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_next = (req_cross && !req_err) ? SPLIT : RESP;
                end else begin
                    state_next = IDLE;
                end
            end
            SPLIT:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // Response stage
    always_comb begin
        req_ready = !rst && (state != SPLIT);
        rsp_valid = (state == RESP);
        rsp_err   = (state == RESP) && err_p1;
        rsp_rdata = '0;
        if ((state == RESP) && !err_p1 && !we_p1) begin
            rsp_rdata = load_extend(f3_p1, {bank_rdata, cross_p1 ? lower_p2 : bank_rdata}, o_p1);
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomised bench for data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;
    import dmem_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem_m [4*DEPTH];

    data_mem_unit #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH_WORDS  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory and the access rules, one byte at a time.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic err, output logic split);
        int n;
        longint w;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        w = longint'(addr) / 4;
        split = (int'(addr % 4) + n) > 4;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) ||
              (w >= DEPTH) || (split && (w + 1 >= DEPTH));
        rd = '0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) mem_m[int'(addr) + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < n; k++) rd[8*k +: 8] = mem_m[int'(addr) + k];
                if (f3 < 3'd4 && n < 4) begin
                    for (int b = 8*n; b < 32; b++) rd[b] = rd[8*n-1];
                end
            end
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        logic [31:0] erd;
        logic        eerr, esplit;
        int          lat;
        bit          seen;
        @(negedge clk);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        model(we, f3, addr, wd, erd, eerr, esplit);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        seen = 1'b0;
        lat  = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (c == 0 && esplit && !eerr) chk("ready_in_split", {31'd0, req_ready}, 32'd0);
            if (rsp_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk("rsp_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("latency", lat, (esplit && !eerr) ? 32'd1 : 32'd0);
            chk("rdata", rsp_rdata, erd);
            chk("err", {31'd0, rsp_err}, {31'd0, eerr});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b2b [8];
        logic [31:0] erd;
        logic        eerr, esplit;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        chk("valid_after_rst", {31'd0, rsp_valid}, 32'd0);

        // Give every word a known value so random loads have defined expectations
        for (int i = 0; i < DEPTH; i++) xact(1'b1, F3_W, 32'(4*i), $urandom);

        xact(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        xact(1'b0, F3_W, 32'h10, 32'h0);
        xact(1'b1, F3_B, 32'h21, 32'h12345680);
        xact(1'b0, F3_B, 32'h21, 32'h0);
        xact(1'b0, F3_BU, 32'h21, 32'h0);
        xact(1'b0, F3_W, 32'h20, 32'h0);
        xact(1'b1, F3_W, 32'h10, 32'h44332211);
        xact(1'b1, F3_W, 32'h14, 32'h88776655);
        xact(1'b0, F3_W, 32'h13, 32'h0);
        xact(1'b0, F3_HU, 32'h17, 32'h0);
        xact(1'b0, F3_W, 32'(4*DEPTH), 32'h0);
        xact(1'b0, F3_W, 32'(4*DEPTH - 2), 32'h0);
        xact(1'b1, F3_BU, 32'h24, 32'hFFFFFFFF);
        xact(1'b0, F3_W, 32'h24, 32'h0);
        xact(1'b0, 3'b111, 32'h8, 32'h0);

        // Reset while the split store sits in SPLIT: only the lower half lands
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0E;
        req_wdata  = 32'hAABBCCDD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_m[32'h0E] = 8'hDD;
        mem_m[32'h0F] = 8'hCC;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("split_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("split_rst_valid0", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("split_rst_valid1", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("split_rst_valid2", {31'd0, rsp_valid}, 32'd0);
        chk("split_rst_ready2", {31'd0, req_ready}, 32'd1);
        xact(1'b0, F3_HU, 32'h0E, 32'h0);
        xact(1'b0, F3_W, 32'h10, 32'h0);

        // Back-to-back aligned loads with req_valid held high
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
                chk("b2b_rdata", rsp_rdata, exp_b2b[i-1]);
            end
            if (i < 8) begin
                model(1'b0, F3_W, 32'(4*i), 32'h0, erd, eerr, esplit);
                exp_b2b[i] = erd;
                req_valid  = 1'b1;
                req_we     = 1'b0;
                req_funct3 = F3_W;
                req_addr   = 32'(4*i);
            end else begin
                req_valid = 1'b0;
            end
        end

        for (int i = 0; i < 300; i++) begin
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 4*DEPTH + 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
